mem_port_arbiter: RTL and testbench

//  Merges the CPU datapath's two word ports (i_mem_*, d_mem_*) onto one physical memory port.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_sat_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, port identifiers
// and the round-robin pick function.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    // Picks the side to serve. If only one side requests, that side wins.
    // If both request, the side that was not served last wins.
    function automatic arb_port_t pickPort(input logic reqI,
                                           input logic reqD,
                                           input arb_port_t lastGrant);
        arb_port_t pick;
        if (reqI && reqD) begin
            pick = (lastGrant == PORT_I) ? PORT_D : PORT_I;
        end else if (reqD) begin
            pick = PORT_D;
        end else begin
            pick = PORT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Advance by one when enabled, unless already at the maximum value.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the instruction and data word ports of the datapath onto one
// physical memory port. One transaction at a time; round-robin when both
// sides request together. Keeps saturating per-port completion counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    i_mem_read,
    input  logic [ADDR_WIDTH-1:0]   i_mem_address,
    output logic                    i_mem_resp,
    output logic [DATA_WIDTH-1:0]   i_mem_rdata,

    input  logic                    d_mem_read,
    input  logic                    d_mem_write,
    input  logic [ADDR_WIDTH-1:0]   d_mem_address,
    input  logic [DATA_WIDTH-1:0]   d_mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_mem_byte_enable,
    output logic                    d_mem_resp,
    output logic [DATA_WIDTH-1:0]   d_mem_rdata,

    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [ADDR_WIDTH-1:0]   pmem_address,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
    output logic [DATA_WIDTH/8-1:0] pmem_byte_enable,
    input  logic                    pmem_resp,
    input  logic [DATA_WIDTH-1:0]   pmem_rdata,

    output logic [CNT_WIDTH-1:0]    i_grant_count,
    output logic [CNT_WIDTH-1:0]    d_grant_count
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_t              state_q,     state_d;
    arb_port_t               lastGrant_q, lastGrant_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [BE_WIDTH-1:0]     be_q,        be_d;
    logic                    write_q,     write_d;

    logic                    reqI;
    logic                    reqD;
    arb_port_t               grant;
    logic                    serving;

    assign reqI  = i_mem_read;
    assign reqD  = d_mem_read | d_mem_write;
    assign grant = pickPort(reqI, reqD, lastGrant_q);

    // Next-state logic: latch the granted request in IDLE, return to IDLE
    // and remember the served side when memory completes.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        write_d     = write_q;
        case (state_q)
            IDLE: begin
                if (reqI || reqD) begin
                    if (grant == PORT_D) begin
                        state_d = SERVE_D;
                        addr_d  = d_mem_address;
                        wdata_d = d_mem_wdata;
                        be_d    = d_mem_byte_enable;
                        write_d = d_mem_write;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = i_mem_address;
                        wdata_d = '0;
                        be_d    = '1;
                        write_d = 1'b0;
                    end
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d     = IDLE;
                    lastGrant_d = PORT_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d     = IDLE;
                    lastGrant_d = PORT_D;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request-latch registers; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lastGrant_q <= PORT_I;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            write_q     <= write_d;
        end
    end

    // Memory side is driven only from the latch. Gating with reset_n keeps
    // an aborted transaction from strobing or completing during reset.
    assign serving          = (state_q != IDLE) && reset_n;
    assign pmem_read        = serving && !write_q;
    assign pmem_write       = serving && write_q;
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;

    assign i_mem_resp  = (state_q == SERVE_I) && pmem_resp && reset_n;
    assign d_mem_resp  = (state_q == SERVE_D) && pmem_resp && reset_n;
    assign i_mem_rdata = i_mem_resp ? pmem_rdata : '0;
    assign d_mem_rdata = d_mem_resp ? pmem_rdata : '0;

    sat_counter #(.WIDTH(CNT_WIDTH)) uICount (
        .clk     (clk),
        .clear_n (reset_n),
        .en      (i_mem_resp),
        .count_o (i_grant_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) uDCount (
        .clk     (clk),
        .clear_n (reset_n),
        .en      (d_mem_resp),
        .count_o (d_grant_count)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Uses a 2-bit counter width so
// counter saturation is reachable in a handful of transactions.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int CW = 2;

    logic            clk;
    logic            reset_n;
    logic            i_mem_read;
    logic [AW-1:0]   i_mem_address;
    logic            i_mem_resp;
    logic [DW-1:0]   i_mem_rdata;
    logic            d_mem_read;
    logic            d_mem_write;
    logic [AW-1:0]   d_mem_address;
    logic [DW-1:0]   d_mem_wdata;
    logic [DW/8-1:0] d_mem_byte_enable;
    logic            d_mem_resp;
    logic [DW-1:0]   d_mem_rdata;
    logic            pmem_read;
    logic            pmem_write;
    logic [AW-1:0]   pmem_address;
    logic [DW-1:0]   pmem_wdata;
    logic [DW/8-1:0] pmem_byte_enable;
    logic            pmem_resp;
    logic [DW-1:0]   pmem_rdata;
    logic [CW-1:0]   i_grant_count;
    logic [CW-1:0]   d_grant_count;

    int vectors;
    int miscompares;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_mem_read        (i_mem_read),
        .i_mem_address     (i_mem_address),
        .i_mem_resp        (i_mem_resp),
        .i_mem_rdata       (i_mem_rdata),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_address     (d_mem_address),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_byte_enable (d_mem_byte_enable),
        .d_mem_resp        (d_mem_resp),
        .d_mem_rdata       (d_mem_rdata),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_byte_enable  (pmem_byte_enable),
        .pmem_resp         (pmem_resp),
        .pmem_rdata        (pmem_rdata),
        .i_grant_count     (i_grant_count),
        .d_grant_count     (d_grant_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then step off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a synchronous reset edge with all requests idle.
    task automatic doReset();
        reset_n     = 1'b0;
        i_mem_read  = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        pmem_resp   = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Reset while I requests: everything idle; first edge after release serves I.
    task automatic test_reset();
        reset_n           = 1'b0;
        i_mem_read        = 1'b1;
        i_mem_address     = 16'h0040;
        d_mem_read        = 1'b0;
        d_mem_write       = 1'b0;
        d_mem_address     = 16'h0000;
        d_mem_wdata       = 16'h0000;
        d_mem_byte_enable = 2'b00;
        pmem_resp         = 1'b0;
        pmem_rdata        = 16'h0000;
        tick();
        tick();
        vectors++;
        if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got %b, expected 0000", {pmem_read, pmem_write, i_mem_resp, d_mem_resp});
        end
        vectors++;
        if ({i_grant_count, d_grant_count} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_counts: got %h, expected 0", {i_grant_count, d_grant_count});
        end
        vectors++;
        if (pmem_address !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %h, expected 0000", pmem_address);
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 16'h0040) begin
            miscompares++;
            $display("[TB] FAIL first_serve_i: got rd/wr %b addr %h, expected 10 addr 0040", {pmem_read, pmem_write}, pmem_address);
        end
    endtask

    // I read completes three cycles later; resp and data coincide with pmem_resp.
    task automatic test_i_read();
        tick();
        tick();
        vectors++;
        if (pmem_read !== 1'b1 || i_mem_resp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL i_read_wait: got rd %b resp %b, expected rd 1 resp 0", pmem_read, i_mem_resp);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = 16'h1234;
        #1;
        vectors++;
        if (i_mem_resp !== 1'b1 || i_mem_rdata !== 16'h1234) begin
            miscompares++;
            $display("[TB] FAIL i_read_resp: got resp %b data %h, expected 1 1234", i_mem_resp, i_mem_rdata);
        end
        vectors++;
        if (d_mem_resp !== 1'b0 || d_mem_rdata !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL i_read_d_quiet: got resp %b data %h, expected 0 0000", d_mem_resp, d_mem_rdata);
        end
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = 16'h0000;
        i_mem_read = 1'b0;
        #1;
        vectors++;
        if (i_grant_count !== 2'd1 || pmem_read !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL i_read_done: got count %0d rd %b, expected 1 0", i_grant_count, pmem_read);
        end
    endtask

    // Both sides request continuously after reset: D, then I, then D.
    task automatic test_round_robin();
        logic [AW-1:0] expAddr [3];
        logic [1:0]    expResp [3];
        expAddr[0] = 16'h3000; expResp[0] = 2'b01;
        expAddr[1] = 16'h0100; expResp[1] = 2'b10;
        expAddr[2] = 16'h3000; expResp[2] = 2'b01;
        doReset();
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0100;
        d_mem_read    = 1'b1;
        d_mem_address = 16'h3000;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (pmem_address !== expAddr[k] || pmem_read !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rr_grant%0d: got addr %h rd %b, expected %h 1", k, pmem_address, pmem_read, expAddr[k]);
            end
            pmem_resp  = 1'b1;
            pmem_rdata = 16'hAAAA;
            #1;
            vectors++;
            if ({i_mem_resp, d_mem_resp} !== expResp[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_resp%0d: got i/d %b, expected %b", k, {i_mem_resp, d_mem_resp}, expResp[k]);
            end
            tick();
            pmem_resp  = 1'b0;
            pmem_rdata = 16'h0000;
            #1;
            vectors++;
            if (pmem_read !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rr_idle%0d: got rd %b, expected 0", k, pmem_read);
            end
        end
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        tick();
        vectors++;
        if (i_grant_count !== 2'd1 || d_grant_count !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL rr_counts: got i %0d d %0d, expected 1 2", i_grant_count, d_grant_count);
        end
    endtask

    // D write: strobes, data and lanes come from the latch, not live inputs.
    task automatic test_d_write();
        d_mem_write       = 1'b1;
        d_mem_address     = 16'h2000;
        d_mem_wdata       = 16'hBEEF;
        d_mem_byte_enable = 2'b01;
        tick();
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b01 || pmem_wdata !== 16'hBEEF || pmem_byte_enable !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL wr_strobe: got rd/wr %b wdata %h be %b, expected 01 BEEF 01", {pmem_read, pmem_write}, pmem_wdata, pmem_byte_enable);
        end
        d_mem_address     = 16'h2222;
        d_mem_wdata       = 16'h0000;
        d_mem_byte_enable = 2'b10;
        tick();
        vectors++;
        if (pmem_address !== 16'h2000 || pmem_wdata !== 16'hBEEF || pmem_byte_enable !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL wr_hold: got addr %h wdata %h be %b, expected 2000 BEEF 01", pmem_address, pmem_wdata, pmem_byte_enable);
        end
        pmem_resp = 1'b1;
        #1;
        vectors++;
        if (d_mem_resp !== 1'b1 || i_mem_resp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_resp: got d %b i %b, expected 1 0", d_mem_resp, i_mem_resp);
        end
        tick();
        pmem_resp   = 1'b0;
        d_mem_write = 1'b0;
        #1;
        vectors++;
        if (d_grant_count !== 2'd3 || pmem_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_done: got count %0d wr %b, expected 3 0", d_grant_count, pmem_write);
        end
    endtask

    // Reset during SERVE_D with pmem_resp high aborts without a resp.
    task automatic test_reset_abort();
        d_mem_read    = 1'b1;
        d_mem_address = 16'h4000;
        tick();
        vectors++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h4000) begin
            miscompares++;
            $display("[TB] FAIL abort_serve: got rd %b addr %h, expected 1 4000", pmem_read, pmem_address);
        end
        reset_n    = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = 16'h5555;
        #1;
        vectors++;
        if (d_mem_resp !== 1'b0 || d_mem_rdata !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL abort_no_resp: got resp %b data %h, expected 0 0000", d_mem_resp, d_mem_rdata);
        end
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = 16'h0000;
        #1;
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b00 || {i_grant_count, d_grant_count} !== 4'b0000 || pmem_address !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL abort_cleared: got rd/wr %b counts %h addr %h, expected 00 0 0000", {pmem_read, pmem_write}, {i_grant_count, d_grant_count}, pmem_address);
        end
        reset_n = 1'b1;
        tick();
        pmem_resp = 1'b1;
        #1;
        vectors++;
        if (d_mem_resp !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_retry: got resp %b, expected 1", d_mem_resp);
        end
        tick();
        pmem_resp  = 1'b0;
        d_mem_read = 1'b0;
        #1;
        vectors++;
        if (d_grant_count !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL abort_retry_count: got %0d, expected 1", d_grant_count);
        end
    endtask

    // Five I transactions on a 2-bit counter: 1, 2, 3, 3, 3.
    task automatic test_saturation();
        logic [CW-1:0] expCount;
        doReset();
        i_mem_address = 16'h0200;
        for (int k = 0; k < 5; k++) begin
            expCount = (k < 3) ? CW'(k + 1) : 2'd3;
            i_mem_read = 1'b1;
            tick();
            pmem_resp = 1'b1;
            tick();
            pmem_resp  = 1'b0;
            i_mem_read = 1'b0;
            #1;
            vectors++;
            if (i_grant_count !== expCount) begin
                miscompares++;
                $display("[TB] FAIL sat_count%0d: got %0d, expected %0d", k, i_grant_count, expCount);
            end
            tick();
        end
    endtask

    // Read and write asserted together behave as a write.
    task automatic test_read_write_both();
        d_mem_read    = 1'b1;
        d_mem_write   = 1'b1;
        d_mem_address = 16'h6000;
        tick();
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rw_both: got rd/wr %b, expected 01", {pmem_read, pmem_write});
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp   = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        #1;
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b00 || d_grant_count !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL rw_both_done: got rd/wr %b count %0d, expected 00 1", {pmem_read, pmem_write}, d_grant_count);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_i_read();
        test_round_robin();
        test_d_write();
        test_reset_abort();
        test_saturation();
        test_read_write_both();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
